io_bus_arbiter: RTL and testbench

- Two-requester arbiter for the memory-mapped IO bus (addresses 0x8000000–0x8000006: SPART, DVI config, tick counter).
- Shares the single IO slave port between the CPU D-cache IO path (m0) and the NPU IO path (m1).
- Arbitration is round-robin. Each granted request is latched and replayed to the slave with a clean valid/ready handshake.
- Sits between the requesters and the IO address-map/decode block.

---
 rtl/io_bus_arbiter_if.sv | 45 ++++
 rtl/io_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_io_bus_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/io_bus_arbiter_if.sv
// Bundled requester (m0/m1) and IO-slave (s_*) signals of the IO bus arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface io_bus_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 28
);
  logic              m0_valid;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wr;
  logic [DATA_W-1:0] m0_rd;
  logic              m0_ready;

  logic              m1_valid;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wr;
  logic [DATA_W-1:0] m1_rd;
  logic              m1_ready;

  logic              s_valid;
  logic              s_rw;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wr;
  logic [DATA_W-1:0] s_rd;
  logic              s_ready;

  modport slave (
    input  m0_valid, m0_rw, m0_addr, m0_wr,
    output m0_rd, m0_ready,
    input  m1_valid, m1_rw, m1_addr, m1_wr,
    output m1_rd, m1_ready,
    output s_valid, s_rw, s_addr, s_wr,
    input  s_rd, s_ready
  );

  modport master (
    output m0_valid, m0_rw, m0_addr, m0_wr,
    input  m0_rd, m0_ready,
    output m1_valid, m1_rw, m1_addr, m1_wr,
    input  m1_rd, m1_ready,
    input  s_valid, s_rw, s_addr, s_wr,
    output s_rd, s_ready
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the IO slave port between CPU (m0) and NPU (m1).
// Optional slave no-response timeout enabled by defining IO_ARB_TIMEOUT_EN.
module io_bus_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 28,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_arbiter_if.slave  bus,
  output logic             grant,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [DATA_W-1:0] TIMEOUT_RD = DATA_W'(32'hDEADBEEF);

  state_t            state, state_nxt;
  logic              last_grant;
  logic              grant_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wr_q;
  logic              req_any;
  logic              pick;
  logic              timeout;
  logic              done;
  logic [DATA_W-1:0] rd_resp;

  assign req_any = bus.m0_valid | bus.m1_valid;

  // On a tie the requester that did not win last time takes the bus.
  always_comb begin
    pick = 1'b0;
    if (bus.m0_valid && bus.m1_valid) pick = ~last_grant;
    else if (bus.m1_valid)            pick = 1'b1;
  end

`ifdef IO_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;
  logic        err_q;

  assign timeout = (state == BUSY) && !bus.s_ready &&
                   (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && req_any) to_cnt <= '0;
      else if (state == BUSY)       to_cnt <= to_cnt + 16'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (bus.s_ready || timeout) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wr_q       <= '0;
    end else if (state == IDLE && req_any) begin
      last_grant <= pick;
      grant_q    <= pick;
      rw_q       <= pick ? bus.m1_rw   : bus.m0_rw;
      addr_q     <= pick ? bus.m1_addr : bus.m0_addr;
      wr_q       <= pick ? bus.m1_wr   : bus.m0_wr;
    end
  end

  // Completion is gated by rst so an aborted transaction never pulses ready.
  assign done    = (state == BUSY) && (bus.s_ready || timeout) && !rst;
  assign rd_resp = bus.s_ready ? bus.s_rd : TIMEOUT_RD;

  always_comb begin
    bus.m0_ready = 1'b0;
    bus.m0_rd    = '0;
    bus.m1_ready = 1'b0;
    bus.m1_rd    = '0;
    if (done) begin
      if (grant_q) begin
        bus.m1_ready = 1'b1;
        bus.m1_rd    = rd_resp;
      end else begin
        bus.m0_ready = 1'b1;
        bus.m0_rd    = rd_resp;
      end
    end
  end

  assign bus.s_valid = (state == BUSY);
  assign bus.s_rw    = rw_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wr    = wr_q;
  assign grant       = grant_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized bench for io_bus_arbiter against a cycle-level rule model of the arbitration.
// Define IO_ARB_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=8).
module tb_io_bus_arbiter;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 28;
`ifdef IO_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 1024;
`endif
  localparam int unsigned N_CYC = 3000;

  logic clk = 1'b0;
  logic rst;
  logic grant;
  logic err;

  io_bus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

  io_bus_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .grant (grant),
    .err   (err)
  );

  always #5 clk = ~clk;

  int unsigned n_pass;
  int unsigned n_total;
  int unsigned cyc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    else
      n_pass++;
  endtask

  // Reference model: who owns the bus, the request it captured, and the slave's plan.
  int                serving;
  bit                gap;
  bit                last;
  bit                grant_exp;
  bit                err_exp;
  bit                model_ok;
  bit                directed;
  bit                done_prev [2];
  int unsigned       lat;
  int unsigned       busy_age;
  logic              lrw;
  logic [ADDR_W-1:0] laddr;
  logic [DATA_W-1:0] lwr;

  logic              v  [2];
  logic              rw [2];
  logic [ADDR_W-1:0] ad [2];
  logic [DATA_W-1:0] wd [2];

  bit                rst_drv;
  bit                silent;
  bit                to_fire;
  bit                done;
  bit                win;
  logic [DATA_W-1:0] exp_rd;

  initial begin
    n_pass = 0; n_total = 0;
    serving = -1; gap = 0; last = 1; grant_exp = 0; err_exp = 0;
    model_ok = 0; directed = 0; lat = 0; busy_age = 0;
    lrw = 0; laddr = '0; lwr = '0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; rw[i] = 0; ad[i] = '0; wd[i] = '0; done_prev[i] = 0;
    end
    rst = 1'b1;
    bus.m0_valid = 0; bus.m0_rw = 0; bus.m0_addr = '0; bus.m0_wr = '0;
    bus.m1_valid = 0; bus.m1_rw = 0; bus.m1_addr = '0; bus.m1_wr = '0;
    bus.s_ready = 0; bus.s_rd = '0;

    for (cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      rst_drv = (cyc < 3) || (cyc >= 40 && $urandom_range(0, 99) == 0);
      rst     = rst_drv;
      silent  = (cyc >= 2000 && cyc < 2100);

      for (int i = 0; i < 2; i++) begin
        if (cyc < 3) begin
          v[i] = 0;
        end else if (cyc == 3) begin
          v[i]  = 1;
          rw[i] = (i == 1);
          ad[i] = (i == 1) ? 28'h8000001 : 28'h8000006;
          wd[i] = (i == 1) ? 32'hCAFE0001 : 32'h0;
        end else if (serving == i || done_prev[i] || !v[i]) begin
          // Owner scrambles its lines mid-transaction; idle requesters raise new ones.
          v[i]  = (serving == i || done_prev[i]) ? ($urandom_range(0, 3) != 0)
                                                 : ($urandom_range(0, 2) == 0);
          rw[i] = $urandom_range(0, 1);
          ad[i] = 28'h8000000 + ADDR_W'($urandom_range(0, 6));
          wd[i] = $urandom;
        end
        done_prev[i] = 0;
      end
      bus.m0_valid = v[0]; bus.m0_rw = rw[0]; bus.m0_addr = ad[0]; bus.m0_wr = wd[0];
      bus.m1_valid = v[1]; bus.m1_rw = rw[1]; bus.m1_addr = ad[1]; bus.m1_wr = wd[1];

      if (serving >= 0) bus.s_ready = !silent && (lat == 0);
      else              bus.s_ready = ($urandom_range(0, 4) == 0);
      bus.s_rd = (directed && serving >= 0) ? 32'h0000002A : $urandom;

`ifdef IO_ARB_TIMEOUT_EN
      to_fire = (serving >= 0) && !bus.s_ready && (busy_age == TO - 1);
`else
      to_fire = 0;
`endif
      done   = (serving >= 0) && !rst_drv && (bus.s_ready || to_fire);
      exp_rd = bus.s_ready ? bus.s_rd : 32'hDEADBEEF;

      #1;
      if (model_ok) begin
        check("s_valid",  bus.s_valid, serving >= 0);
        check("s_rw",     bus.s_rw,    lrw);
        check("s_addr",   bus.s_addr,  laddr);
        check("s_wr",     bus.s_wr,    lwr);
        check("grant",    grant,       grant_exp);
        check("err",      err,         err_exp);
        check("m0_ready", bus.m0_ready, done && serving == 0);
        check("m0_rd",    bus.m0_rd,    (done && serving == 0) ? exp_rd : 32'h0);
        check("m1_ready", bus.m1_ready, done && serving == 1);
        check("m1_rd",    bus.m1_rd,    (done && serving == 1) ? exp_rd : 32'h0);
      end
      if (cyc == 3) check("rst_s_addr_zero", bus.s_addr, 28'h0);
      if (cyc == 4) check("first_s_valid", bus.s_valid, 1'b1);
      if (cyc == 5) begin
        check("first_m0_ready", bus.m0_ready, 1'b1);
        check("first_m0_rd",    bus.m0_rd,    32'h0000002A);
        check("first_m1_quiet", bus.m1_ready, 1'b0);
      end
      if (cyc == 6) check("first_release", bus.s_valid, 1'b0);
      if (cyc == 8) check("tie_second_grant", grant, 1'b1);

      if (rst_drv) begin
        serving = -1; gap = 0; last = 1; grant_exp = 0; err_exp = 0;
        lrw = 0; laddr = '0; lwr = '0; busy_age = 0; directed = 0;
        model_ok = 1;
      end else if (serving >= 0) begin
        if (done) begin
          done_prev[serving] = 1;
          if (!bus.s_ready) err_exp = 1;
          serving = -1; gap = 1; directed = 0;
        end else begin
          busy_age++;
          if (lat > 0) lat--;
        end
      end else if (gap) begin
        gap = 0;
      end else if (v[0] || v[1]) begin
        win       = (v[0] && v[1]) ? !last : v[1];
        last      = win;
        grant_exp = win;
        lrw       = rw[win];
        laddr     = ad[win];
        lwr       = wd[win];
        serving   = int'(win);
        busy_age  = 0;
        directed  = (cyc == 3);
        lat       = (cyc == 3) ? 1 : $urandom_range(0, 3);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
